// File: rtl/dvi_timing_ctrl_if.sv
// Timing-configuration handshake bundle between a mode source and dvi_timing_ctrl.
// Carries the offered H/V timing words plus the accept/reject/apply indications.
// master offers timing; slave (the controller) answers with ready/err/done.
interface dvi_timing_ctrl_if #(
  parameter int CW = 11
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [4*CW-1:0] cfg_h;
  logic [4*CW-1:0] cfg_v;
  logic          cfg_err;
  logic          cfg_done;

  modport master (
    output cfg_valid, cfg_h, cfg_v,
    input  cfg_ready, cfg_err, cfg_done
  );

  modport slave (
    input  cfg_valid, cfg_h, cfg_v,
    output cfg_ready, cfg_err, cfg_done
  );
endinterface

// File: rtl/dvi_timing_ctrl.sv
// Programmable DVI video timing generator: pixel/line counters plus registered decode.
// Latency: draw_area/hsync/vsync/frame_start lag the counters by 1 cycle; cfg_err 1 cycle after offer.
// Backpressure: cfg_ready drops while a new timing is pending until it lands at a frame boundary.
module dvi_timing_ctrl #(
  parameter int CW    = 11,
  parameter int H_ACT = 960,
  parameter int H_SS  = 960,
  parameter int H_SE  = 961,
  parameter int H_TOT = 1041,
  parameter int V_ACT = 540,
  parameter int V_SS  = 540,
  parameter int V_SE  = 541,
  parameter int V_TOT = 585
) (
  input  logic            pixclk,
  input  logic            reset,
  dvi_timing_ctrl_if.slave cfg,
  output logic [CW-1:0]   counter_x,
  output logic [CW-1:0]   counter_y,
  output logic            draw_area,
  output logic            hsync,
  output logic            vsync,
  output logic            frame_start
);

  // One axis of timing; field order matches the {tot, se, ss, act} packing of cfg_h/cfg_v.
  typedef struct packed {
    logic [CW-1:0] tot;
    logic [CW-1:0] se;
    logic [CW-1:0] ss;
    logic [CW-1:0] act;
  } tim_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  localparam tim_t DEF_H = '{tot: CW'(H_TOT), se: CW'(H_SE), ss: CW'(H_SS), act: CW'(H_ACT)};
  localparam tim_t DEF_V = '{tot: CW'(V_TOT), se: CW'(V_SE), ss: CW'(V_SS), act: CW'(V_ACT)};

  // 0 < act <= ss < se <= tot-1; written as se < tot so tot==0 cannot underflow.
  function automatic logic tim_ok(tim_t t);
    return (t.act != '0) && (t.act <= t.ss) && (t.ss < t.se) && (t.se < t.tot);
  endfunction

  state_t        state_q, state_d;
  tim_t          act_h_q, act_h_d, act_v_q, act_v_d;
  tim_t          shd_h_q, shd_h_d, shd_v_q, shd_v_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          draw_q, draw_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic          err_q, err_d;
  logic          wrap_x, wrap_y, last_pix;

  // Counter advance, registered decode and the config FSM next-state.
  always_comb begin
    state_d = state_q;
    act_h_d = act_h_q;
    act_v_d = act_v_q;
    shd_h_d = shd_h_q;
    shd_v_d = shd_v_q;
    err_d   = 1'b0;

    // >= rather than == so counters left above a shrunk total still wrap.
    wrap_x   = (x_q >= act_h_q.tot - CW'(1));
    wrap_y   = (y_q >= act_v_q.tot - CW'(1));
    last_pix = wrap_x && wrap_y;

    x_d = wrap_x ? '0 : x_q + CW'(1);
    y_d = y_q;
    if (wrap_x) y_d = wrap_y ? '0 : y_q + CW'(1);

    draw_d = (x_q < act_h_q.act) && (y_q < act_v_q.act);
    hs_d   = (x_q >= act_h_q.ss) && (x_q < act_h_q.se);
    vs_d   = (y_q >= act_v_q.ss) && (y_q < act_v_q.se);
    fs_d   = (x_q == '0) && (y_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          if (tim_ok(tim_t'(cfg.cfg_h)) && tim_ok(tim_t'(cfg.cfg_v))) begin
            shd_h_d = tim_t'(cfg.cfg_h);
            shd_v_d = tim_t'(cfg.cfg_v);
            state_d = ST_PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        // Swap only on the last pixel so the new frame starts cleanly at 0,0.
        if (last_pix) begin
          act_h_d = shd_h_q;
          act_v_d = shd_v_q;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timing and output registers; reset restores defaults and drops any pending timing.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      act_h_q <= DEF_H;
      act_v_q <= DEF_V;
      shd_h_q <= DEF_H;
      shd_v_q <= DEF_V;
      x_q     <= '0;
      y_q     <= '0;
      draw_q  <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_h_q <= act_h_d;
      act_v_q <= act_v_d;
      shd_h_q <= shd_h_d;
      shd_v_q <= shd_v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      draw_q  <= draw_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign cfg.cfg_done  = (state_q == ST_APPLY);
  assign cfg.cfg_err   = err_q;
  assign counter_x     = x_q;
  assign counter_y     = y_q;
  assign draw_area     = draw_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign frame_start   = fs_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Randomized bench for dvi_timing_ctrl with a frame-linear pixel-index reference model.
// Small default timing keeps frames short (24x15 = 360 cycles).
// Inputs driven on the falling edge, outputs compared on the falling edge.
module tb_dvi_timing_ctrl;
  localparam int CW = 11;
  localparam int W  = 2*CW + 7;
  localparam int H_ACT = 16, H_SS = 18, H_SE = 20, H_TOT = 24;
  localparam int V_ACT = 10, V_SS = 11, V_SE = 13, V_TOT = 15;
  localparam int DEF_N = H_TOT * V_TOT;

  logic pixclk, reset;
  logic [CW-1:0] counter_x, counter_y;
  logic draw_area, hsync, vsync, frame_start;
  int n_chk, n_pass;

  dvi_timing_ctrl_if #(.CW(CW)) bus ();

  dvi_timing_ctrl #(
    .CW(CW), .H_ACT(H_ACT), .H_SS(H_SS), .H_SE(H_SE), .H_TOT(H_TOT),
    .V_ACT(V_ACT), .V_SS(V_SS), .V_SE(V_SE), .V_TOT(V_TOT)
  ) dut (
    .pixclk(pixclk), .reset(reset), .cfg(bus.slave),
    .counter_x(counter_x), .counter_y(counter_y), .draw_area(draw_area),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  initial begin
    pixclk = 1'b0;
    forever #5 pixclk = ~pixclk;
  end

  // Reference model: position is a linear pixel index within the frame;
  // arrays hold {act, ss, se, tot} as plain integers.
  int mh[4], mv[4], sh[4], sv[4];
  int m_p, m_state;  // 0 idle, 1 waiting for frame end, 2 just applied
  bit m_draw, m_hs, m_vs, m_fs, m_err;

  function automatic bit tok(int a, int s, int e, int t);
    return (a > 0) && (a <= s) && (s < e) && (e <= t - 1);
  endfunction

  task automatic model_reset();
    mh = '{H_ACT, H_SS, H_SE, H_TOT};
    mv = '{V_ACT, V_SS, V_SE, V_TOT};
    m_p = 0; m_state = 0;
    m_draw = 0; m_hs = 0; m_vs = 0; m_fs = 0; m_err = 0;
  endtask

  task automatic model_step();
    int x, y, nh[4], nv[4];
    bit last;
    x = m_p % mh[3];
    y = m_p / mh[3];
    last = (m_p == mh[3] * mv[3] - 1);
    if (reset) begin
      model_reset();
      return;
    end
    m_draw = (x < mh[0]) && (y < mv[0]);
    m_hs   = (x >= mh[1]) && (x < mh[2]);
    m_vs   = (y >= mv[1]) && (y < mv[2]);
    m_fs   = (m_p == 0);
    m_err  = 0;
    case (m_state)
      0: if (bus.cfg_valid) begin
        for (int i = 0; i < 4; i++) begin
          nh[i] = int'(bus.cfg_h[CW*i +: CW]);
          nv[i] = int'(bus.cfg_v[CW*i +: CW]);
        end
        if (tok(nh[0], nh[1], nh[2], nh[3]) && tok(nv[0], nv[1], nv[2], nv[3])) begin
          sh = nh; sv = nv; m_state = 1;
        end else begin
          m_err = 1;
        end
      end
      1: if (last) begin
        mh = sh; mv = sv; m_state = 2;
      end
      default: m_state = 0;
    endcase
    m_p = last ? 0 : m_p + 1;
  endtask

  function automatic logic [W-1:0] exp_vec();
    int x, y;
    x = m_p % mh[3];
    y = m_p / mh[3];
    return {CW'(x), CW'(y), m_draw, m_hs, m_vs, m_fs, (m_state == 0), m_err, (m_state == 2)};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {counter_x, counter_y, draw_area, hsync, vsync, frame_start,
            bus.cfg_ready, bus.cfg_err, bus.cfg_done};
  endfunction

  task automatic tick();
    @(posedge pixclk);
    model_step();
    @(negedge pixclk);
  endtask

  function automatic logic [4*CW-1:0] mk_valid(int lo, int hi);
    int t, a, s, e;
    t = int'($urandom_range(hi, lo));
    a = int'($urandom_range(t - 2, 1));
    s = int'($urandom_range(t - 2, a));
    e = int'($urandom_range(t - 1, s + 1));
    return {CW'(t), CW'(e), CW'(s), CW'(a)};
  endfunction

  function automatic logic [4*CW-1:0] mk_bad(logic [4*CW-1:0] f, int k);
    int a, s, e, t;
    a = int'(f[CW-1:0]);
    s = int'(f[2*CW-1:CW]);
    e = int'(f[3*CW-1:2*CW]);
    t = int'(f[4*CW-1:3*CW]);
    case (k)
      0: a = 0;
      1: e = s;
      2: s = a - 1;
      default: e = t;
    endcase
    return {CW'(t), CW'(e), CW'(s), CW'(a)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      bus.cfg_valid = 1'($urandom_range(1, 0));
      bus.cfg_h = mk_valid(4, 24);
      bus.cfg_v = mk_valid(3, 12);
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if ({bus.cfg_ready, counter_x, counter_y, draw_area, frame_start} !== {1'b1, {(2*CW+2){1'b0}}})
      $display("FAIL reset_values got ready=%b x=%0d y=%0d exp ready=1 x=0 y=0", bus.cfg_ready, counter_x, counter_y);
    else n_pass++;
    bus.cfg_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    int hs_n = 0, vs_n = 0, dr_n = 0, fs1 = -1, fs2 = -1, xmax = 0;
    for (int c = 1; c <= 2 * DEF_N; c++) begin
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL free_run cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
      hs_n += int'(hsync); vs_n += int'(vsync); dr_n += int'(draw_area);
      if (int'(counter_x) > xmax) xmax = int'(counter_x);
      if (frame_start) begin
        if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
      end
    end
    n_chk++;
    if (fs2 - fs1 !== DEF_N || fs1 !== 1) $display("FAIL frame_period got first=%0d period=%0d exp first=1 period=%0d", fs1, fs2 - fs1, DEF_N);
    else n_pass++;
    n_chk++;
    if (hs_n !== 2 * V_TOT * (H_SE - H_SS)) $display("FAIL hsync_count got=%0d exp=%0d", hs_n, 2 * V_TOT * (H_SE - H_SS));
    else n_pass++;
    n_chk++;
    if (vs_n !== 2 * H_TOT * (V_SE - V_SS)) $display("FAIL vsync_count got=%0d exp=%0d", vs_n, 2 * H_TOT * (V_SE - V_SS));
    else n_pass++;
    n_chk++;
    if (dr_n !== 2 * H_ACT * V_ACT) $display("FAIL draw_count got=%0d exp=%0d", dr_n, 2 * H_ACT * V_ACT);
    else n_pass++;
    n_chk++;
    if (xmax !== H_TOT - 1) $display("FAIL x_wrap got max=%0d exp=%0d", xmax, H_TOT - 1);
    else n_pass++;
  endtask

  task automatic test_reconfig();
    int wait_n, nnew, k, fs1 = -1, fs2 = -1;
    bit seen = 0;
    bus.cfg_h = mk_valid(4, 24);
    bus.cfg_v = mk_valid(3, 12);
    nnew = int'(bus.cfg_h[4*CW-1:3*CW]) * int'(bus.cfg_v[4*CW-1:3*CW]);
    wait_n = int'($urandom_range(300, 0));
    for (int c = 0; c < wait_n; c++) begin
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL reconfig_pre cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    n_chk++;
    if (bus.cfg_ready !== 1'b0) $display("FAIL reconfig_ready_drop got=%b exp=0", bus.cfg_ready);
    else n_pass++;
    for (int c = 0; c < 2 * DEF_N + 10 && !seen; c++) begin
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL reconfig_wait cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
      seen = bus.cfg_done;
    end
    n_chk++;
    if (!seen || counter_x !== '0 || counter_y !== '0)
      $display("FAIL reconfig_done got seen=%b x=%0d y=%0d exp seen=1 x=0 y=0", seen, counter_x, counter_y);
    else n_pass++;
    k = 0;
    while (k < 2 * nnew + 10 && fs2 < 0) begin
      tick();
      k++;
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL reconfig_run cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      else n_pass++;
      if (frame_start) begin
        if (fs1 < 0) fs1 = k; else fs2 = k;
      end
    end
    n_chk++;
    if (fs1 !== 1 || fs2 - fs1 !== nnew) $display("FAIL new_period got first=%0d period=%0d exp first=1 period=%0d", fs1, fs2 - fs1, nnew);
    else n_pass++;
  endtask

  task automatic test_invalid();
    for (int j = 0; j < 8; j++) begin
      bus.cfg_h = mk_valid(4, 24);
      bus.cfg_v = mk_valid(3, 12);
      if (j < 2) bus.cfg_h = mk_bad(bus.cfg_h, j);
      else if ($urandom_range(1, 0) == 1) bus.cfg_h = mk_bad(bus.cfg_h, int'($urandom_range(3, 0)));
      else bus.cfg_v = mk_bad(bus.cfg_v, int'($urandom_range(3, 0)));
      bus.cfg_valid = 1'b1;
      tick();
      bus.cfg_valid = 1'b0;
      n_chk++;
      if (bus.cfg_err !== 1'b1 || bus.cfg_ready !== 1'b1) $display("FAIL invalid_err j=%0d got err=%b ready=%b exp err=1 ready=1", j, bus.cfg_err, bus.cfg_ready);
      else n_pass++;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_chk++;
        if (obs_vec() !== exp_vec()) $display("FAIL invalid_after j=%0d got=%h exp=%h", j, obs_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  task automatic test_last_pixel();
    int nold, k;
    nold = mh[3] * mv[3];
    k = 0;
    while (m_p != nold - 1 && k < nold + 2) begin
      tick();
      k++;
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL lastpix_seek cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    bus.cfg_h = mk_valid(4, 24);
    bus.cfg_v = mk_valid(3, 12);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    n_chk++;
    if (bus.cfg_ready !== 1'b0 || bus.cfg_done !== 1'b0) $display("FAIL lastpix_accept got ready=%b done=%b exp ready=0 done=0", bus.cfg_ready, bus.cfg_done);
    else n_pass++;
    k = 0;
    while (!bus.cfg_done && k < 2 * nold + 4) begin
      tick();
      k++;
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL lastpix_wait cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (k !== nold) $display("FAIL lastpix_delay got=%0d exp=%0d", k, nold);
    else n_pass++;
  endtask

  task automatic test_reset_pending();
    int k = 0, dones = 0;
    while (m_p != 1 && k < 2 * DEF_N) begin
      tick();
      k++;
    end
    bus.cfg_h = mk_valid(4, 24);
    bus.cfg_v = mk_valid(3, 12);
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_chk++;
    if (bus.cfg_ready !== 1'b1 || obs_vec() !== exp_vec()) $display("FAIL rst_pending got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    for (int c = 0; c < 2 * DEF_N; c++) begin
      tick();
      dones += int'(bus.cfg_done);
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL rst_pending_run cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (dones !== 0) $display("FAIL rst_pending_done got=%0d exp=0", dones);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 2000; c++) begin
      bus.cfg_valid = ($urandom_range(7, 0) == 0);
      bus.cfg_h = mk_valid(4, 24);
      bus.cfg_v = mk_valid(3, 12);
      if ($urandom_range(1, 0) == 1) bus.cfg_h = mk_bad(bus.cfg_h, int'($urandom_range(3, 0)));
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_h = '0;
    bus.cfg_v = '0;
    model_reset();
    @(negedge pixclk);
    test_reset();
    test_free_run();
    test_reconfig();
    test_invalid();
    test_last_pixel();
    test_reset_pending();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
